arb4_rr: RTL

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb_pkg.sv | 35 +++
 rtl/rr_pick4.sv | 36 +++
 rtl/arb4_rr.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types, sizes and encode helpers for the 4-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int HOLD_W = 4;
    localparam int PCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Returns 0 for an all-zero vector so gnt_id idles at 0.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational priority pick over 4 candidates, starting the
//               search at a given index and wrapping upward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [ID_W-1:0]  start,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [ID_W-1:0] w_idx [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_idx
        assign w_idx[g] = start + ID_W'(g);
    end

    // Walk from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[w_idx[i]]) begin
                winner = w_idx[i];
                found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb4_rr.sv
`default_nettype none
// ============================================================================
// Module      : arb4_rr
// Description : 4-requester arbiter, fixed-priority or round-robin, with a
//               hold-time limit that preempts the owner through a GAP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module arb4_rr
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 gnt_valid,
    output logic [PCNT_W-1:0]    preempt_cnt
);

    state_t              r_state,       w_state_nxt;
    logic [N_REQ-1:0]    r_gnt,         w_gnt_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt,    w_hold_nxt;
    logic [ID_W-1:0]     r_last_owner,  w_last_nxt;
    logic [PCNT_W-1:0]   r_preempt_cnt, w_preempt_nxt;
    logic [ID_W-1:0]     r_excl_id,     w_excl_nxt;

    logic [ID_W-1:0]     w_owner;
    logic [N_REQ-1:0]    w_others;
    logic [N_REQ-1:0]    w_gap_cand;
    logic [N_REQ-1:0]    w_cand;
    logic [ID_W-1:0]     w_start;
    logic [ID_W-1:0]     w_win;
    logic                w_found;
    logic                w_timeout;

    assign w_owner    = onehot_to_id(r_gnt);
    assign w_others   = req & ~r_gnt;
    assign w_gap_cand = req & ~id_to_onehot(r_excl_id);
    assign w_timeout  = (r_hold_cnt >= HOLD_W'(MAX_HOLD));
    assign w_start    = mode ? (r_last_owner + ID_W'(1)) : '0;

    // After a preemption the old owner sits out one decision, unless it is alone.
    always_comb begin
        w_cand = req;
        case (r_state)
            GRANT:   w_cand = w_others;
            GAP:     w_cand = (|w_gap_cand) ? w_gap_cand : req;
            default: w_cand = req;
        endcase
    end

    rr_pick4 u_pick (
        .cand   (w_cand),
        .start  (w_start),
        .winner (w_win),
        .found  (w_found)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_hold_nxt    = r_hold_cnt;
        w_last_nxt    = r_last_owner;
        w_preempt_nxt = r_preempt_cnt;
        w_excl_nxt    = r_excl_id;

        case (r_state)
            IDLE, GAP: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = id_to_onehot(w_win);
                    w_hold_nxt  = HOLD_W'(1);
                    w_last_nxt  = w_win;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[w_owner]) begin
                    // Release wins over a coincident timeout.
                    if (w_found) begin
                        w_gnt_nxt  = id_to_onehot(w_win);
                        w_hold_nxt = HOLD_W'(1);
                        w_last_nxt = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_hold_nxt  = '0;
                    end
                end else if (w_timeout && (|w_others)) begin
                    w_state_nxt   = GAP;
                    w_gnt_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_excl_nxt    = w_owner;
                    w_preempt_nxt = (&r_preempt_cnt) ? r_preempt_cnt
                                                     : r_preempt_cnt + PCNT_W'(1);
                end else begin
                    w_hold_nxt = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_hold_cnt    <= '0;
            r_last_owner  <= ID_W'(N_REQ - 1);
            r_preempt_cnt <= '0;
            r_excl_id     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_last_owner  <= w_last_nxt;
            r_preempt_cnt <= w_preempt_nxt;
            r_excl_id     <= w_excl_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_valid   = |r_gnt;
    assign gnt_id      = onehot_to_id(r_gnt);
    assign preempt_cnt = r_preempt_cnt;

endmodule
`default_nettype wire
